// File: rtl/rt_mem_pkg.sv
// Shared widths and FSM state encoding for the memory-controller line reader.
package rt_mem_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } rd_state_t;

    // Word 0 is the least significant 32 bits of the line.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mc_line_fifo.sv
// Synchronous line FIFO; exposes the head entry and the one behind it so the
// serializer can move straight to the next line without a bubble.
module mc_line_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic [W-1:0]           o_next,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[r_rd_ptr + AW'(1)];
    assign o_count = r_count;

endmodule

// File: rtl/mc_line_reader.sv
// Reads num_lines sequential 128-bit lines from main memory and streams them
// out as 32-bit words, keeping at most one read outstanding.
module mc_line_reader
    import rt_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    output logic              re_MC,
    output logic [31:0]       addr_MC,
    input  logic [LINE_W-1:0] data_MC_out,
    input  logic              rdy_MC,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       LAST_IDX = 2'(WORDS_PER_LINE - 1);

    rd_state_t         r_state;
    logic [LEN_W-1:0]  r_lines_left;
    logic [LEN_W-1:0]  r_lines_to_drain;
    logic              r_busy;
    logic              r_done;
    logic              r_re;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_word_out;
    logic              r_word_valid;
    logic [1:0]        r_idx;

    logic              w_push;
    logic              w_fire;
    logic              w_pop;
    logic [LINE_W-1:0] w_head;
    logic [LINE_W-1:0] w_next_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_after;
    logic              w_empty;
    logic              w_full;
    logic [LEN_W-1:0]  w_drain_after;

    // A completion only counts while a request is actually open.
    assign w_push        = r_re && rdy_MC;
    assign w_fire        = r_word_valid && word_ready;
    assign w_pop         = w_fire && (r_idx == LAST_IDX);
    assign w_count_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_drain_after = r_lines_to_drain - LEN_W'(w_pop);

    mc_line_fifo #(
        .W     (LINE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_MC_out),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_lines_left     <= '0;
            r_lines_to_drain <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_re             <= 1'b0;
            r_addr           <= '0;
        end else begin
            r_done           <= 1'b0;
            r_lines_to_drain <= w_drain_after;
            if (r_done) r_busy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !r_busy) begin
                        r_busy           <= 1'b1;
                        r_lines_left     <= num_lines;
                        r_lines_to_drain <= num_lines;
                        if (num_lines == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= REQ;
                            r_re    <= 1'b1;
                            r_addr  <= base_addr & ~32'hF;
                        end
                    end
                end
                REQ: begin
                    if (w_push) begin
                        r_lines_left <= r_lines_left - LEN_W'(1);
                        r_addr       <= r_addr + 32'(LINE_BYTES);
                        if (r_lines_left == LEN_W'(1)) begin
                            r_state <= DRAIN;
                            r_re    <= 1'b0;
                        end else if (w_count_after == DEPTH_C) begin
                            r_state <= WAIT;
                            r_re    <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!w_full || w_pop) begin
                        r_state <= REQ;
                        r_re    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_drain_after == '0) r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // On the last word of a line the next word comes from the entry behind
    // the head, since the pop only takes effect at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_valid <= 1'b0;
            r_word_out   <= '0;
            r_idx        <= '0;
        end else if (!r_word_valid || w_fire) begin
            if (w_pop) begin
                r_idx        <= '0;
                r_word_valid <= (w_count >= CNT_W'(2));
                r_word_out   <= line_word(w_next_head, 2'd0);
            end else if (w_fire) begin
                r_idx        <= r_idx + 2'd1;
                r_word_out   <= line_word(w_head, r_idx + 2'd1);
            end else begin
                r_word_valid <= !w_empty;
                r_word_out   <= line_word(w_head, r_idx);
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign re_MC      = r_re;
    assign addr_MC    = r_addr;
    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;

endmodule

// File: tb/tb_mc_line_reader.sv
// Directed bench for mc_line_reader with a behavioural memory responder.
module tb_mc_line_reader;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   base_addr;
    logic [15:0]   num_lines;
    logic          busy;
    logic          done;
    logic          re_MC;
    logic [31:0]   addr_MC;
    logic [127:0]  data_MC_out;
    logic          rdy_MC;
    logic [31:0]   word_out;
    logic          word_valid;
    logic          word_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;

    logic [31:0] wq[$];
    logic [31:0] addrq[$];
    int done_cnt, done_cyc, first_re, first_wv;
    bit re_seen, wv_seen;

    bit resp_en   = 1'b1;
    int resp_lat  = 1;
    bit force_rdy = 1'b0;
    int wcnt      = 0;

    mc_line_reader #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .num_lines   (num_lines),
        .busy        (busy),
        .done        (done),
        .re_MC       (re_MC),
        .addr_MC     (addr_MC),
        .data_MC_out (data_MC_out),
        .rdy_MC      (rdy_MC),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mk_word(input logic [31:0] a, input int k);
        return a + 32'h0100_0000 * 32'(k + 1) + 32'h0000_0005;
    endfunction

    function automatic logic [127:0] mk_line(input logic [31:0] a);
        return {mk_word(a, 3), mk_word(a, 2), mk_word(a, 1), mk_word(a, 0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: answers an open request after resp_lat waiting cycles.
    initial begin
        rdy_MC      = 1'b0;
        data_MC_out = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_rdy) begin
                rdy_MC      = 1'b1;
                data_MC_out = {4{32'hBAD0_BAD0}};
            end else if (resp_en && re_MC) begin
                if (wcnt >= resp_lat) begin
                    rdy_MC      = 1'b1;
                    data_MC_out = mk_line(addr_MC);
                    addrq.push_back(addr_MC);
                    wcnt        = 0;
                end else begin
                    rdy_MC = 1'b0;
                    wcnt++;
                end
            end else begin
                rdy_MC = 1'b0;
                wcnt   = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (word_valid && word_ready) wq.push_back(word_out);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (re_MC) begin
            re_seen = 1'b1;
            if (first_re < 0) first_re = cyc;
        end
        if (word_valid) begin
            wv_seen = 1'b1;
            if (first_wv < 0) first_wv = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wq.delete();
        addrq.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_re = -1;
        first_wv = -1;
        re_seen  = 1'b0;
        wv_seen  = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        base_addr = b;
        num_lines = n;
        start     = 1'b1;
        c0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_words(input string tag, input logic [31:0] base, input int n);
        logic [31:0] al;
        al = base & ~32'hF;
        chk($sformatf("%s word count", tag), 64'(wq.size()), 64'(n * 4));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s line%0d word%0d", tag, i, k),
                    64'(q_at(wq, i * 4 + k)), 64'(mk_word(al + 32'(16 * i), k)));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " busy"},       64'(busy),       64'(0));
        chk({tag, " done"},       64'(done),       64'(0));
        chk({tag, " re_MC"},      64'(re_MC),      64'(0));
        chk({tag, " addr_MC"},    64'(addr_MC),    64'(0));
        chk({tag, " word_valid"}, 64'(word_valid), 64'(0));
        chk({tag, " word_out"},   64'(word_out),   64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        num_lines  = '0;
        word_ready = 1'b1;
        clear_logs();
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Latency: memory answers in the first request cycle
        resp_lat = 0;
        clear_logs();
        pulse_start(32'h0000_0800, 16'd1);
        chk("lat busy", 64'(busy), 64'(1));
        chk("lat re_MC", 64'(re_MC), 64'(1));
        wait_done(100);
        chk("lat first re_MC cycle", 64'(first_re), 64'(c0 + 1));
        chk("lat first word_valid cycle", 64'(first_wv), 64'(c0 + 3));
        chk("lat done", 64'(done_cnt), 64'(1));
        check_words("lat", 32'h0000_0800, 1);

        // Test 1: two lines, one-cycle memory latency
        resp_lat = 1;
        clear_logs();
        pulse_start(32'h0000_1000, 16'd2);
        wait_done(200);
        chk("t1 done count", 64'(done_cnt), 64'(1));
        chk("t1 read count", 64'(addrq.size()), 64'(2));
        chk("t1 addr0", 64'(q_at(addrq, 0)), 64'h1000);
        chk("t1 addr1", 64'(q_at(addrq, 1)), 64'h1010);
        check_words("t1", 32'h0000_1000, 2);
        chk("t1 busy after done", 64'(busy), 64'(0));

        // Test 2: back-pressure fills the line buffer
        word_ready = 1'b0;
        clear_logs();
        pulse_start(32'h0000_2000, 16'd8);
        repeat (40) @(negedge clk);
        chk("t2 reads while stalled", 64'(addrq.size()), 64'(4));
        chk("t2 re_MC while stalled", 64'(re_MC), 64'(0));
        chk("t2 word_valid held", 64'(word_valid), 64'(1));
        chk("t2 word_out held", 64'(word_out), 64'(mk_word(32'h0000_2000, 0)));
        chk("t2 busy while stalled", 64'(busy), 64'(1));
        word_ready = 1'b1;
        wait_done(400);
        chk("t2 done count", 64'(done_cnt), 64'(1));
        chk("t2 total reads", 64'(addrq.size()), 64'(8));
        check_words("t2", 32'h0000_2000, 8);

        // Test 3: zero-length transfer
        clear_logs();
        pulse_start(32'h0000_3000, 16'd0);
        repeat (6) @(negedge clk);
        chk("t3 done count", 64'(done_cnt), 64'(1));
        chk("t3 done cycle", 64'(done_cyc), 64'(c0 + 2));
        chk("t3 re_MC seen", 64'(re_seen), 64'(0));
        chk("t3 word_valid seen", 64'(wv_seen), 64'(0));
        chk("t3 busy after", 64'(busy), 64'(0));

        // Test 4: alignment and address wrap
        clear_logs();
        pulse_start(32'h0000_100C, 16'd1);
        wait_done(100);
        chk("t4a addr0", 64'(q_at(addrq, 0)), 64'h1000);
        check_words("t4a", 32'h0000_1000, 1);
        clear_logs();
        pulse_start(32'hFFFF_FFF0, 16'd2);
        wait_done(200);
        chk("t4b addr0", 64'(q_at(addrq, 0)), 64'hFFFF_FFF0);
        chk("t4b addr1", 64'(q_at(addrq, 1)), 64'h0000_0000);
        check_words("t4b", 32'hFFFF_FFF0, 2);

        // Test 5: reset while a request is open, completion arrives late
        resp_en = 1'b0;
        clear_logs();
        pulse_start(32'h0000_3000, 16'd2);
        chk("t5 re_MC before reset", 64'(re_MC), 64'(1));
        rst       = 1'b1;
        force_rdy = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        force_rdy = 1'b0;
        check_reset_outputs("t5 after reset");
        clear_logs();
        repeat (5) @(negedge clk);
        chk("t5 word_valid after stray rdy", 64'(wv_seen), 64'(0));
        chk("t5 re_MC after reset", 64'(re_seen), 64'(0));
        chk("t5 no done", 64'(done_cnt), 64'(0));
        resp_en = 1'b1;
        clear_logs();
        pulse_start(32'h0000_4000, 16'd1);
        wait_done(100);
        chk("t5 restart done", 64'(done_cnt), 64'(1));
        check_words("t5", 32'h0000_4000, 1);

        // Test 6: stray rdy in IDLE and a second start while busy
        clear_logs();
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6 stray rdy word_valid", 64'(wv_seen), 64'(0));
        pulse_start(32'h0000_5000, 16'd2);
        repeat (2) @(negedge clk);
        pulse_start(32'h0000_9000, 16'd5);
        wait_done(200);
        repeat (10) @(negedge clk);
        chk("t6 done count", 64'(done_cnt), 64'(1));
        chk("t6 read count", 64'(addrq.size()), 64'(2));
        check_words("t6", 32'h0000_5000, 2);
        chk("t6 busy after", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
